// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine feeding the HiLo register.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Signs are stripped before the loop and reapplied in a single fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic                 HiLoEn,
  output logic [2*WIDTH-1:0]   HiLoWrite,
  output logic                 DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, next_state;

  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               zero_div;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH:0]   acc;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic               start_zero_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH:0]   div_next;

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] fixed;

  // Operand magnitudes and sign flags; the most negative value keeps its bit pattern as an unsigned magnitude
  always_comb begin
    is_signed      = ~Op[0];
    a_neg          = is_signed & A[WIDTH-1];
    b_neg          = is_signed & B[WIDTH-1];
    a_mag          = a_neg ? (-A) : A;
    b_mag          = b_neg ? (-B) : B;
    start_zero_div = Op[1] & (B == '0);
  end

  // One shift-add step: conditionally add the multiplicand to the upper half, then shift right
  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-division step: remainder sits in the upper half, quotient in the lower half
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, operand};
    div_rem   = div_fits ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
    div_next  = {1'b0, div_rem, acc[WIDTH-2:0], div_fits};
  end

  // Sign fix-up of the unsigned loop result
  always_comb begin
    product = (sign_a ^ sign_b) ? (-acc[2*WIDTH-1:0]) : acc[2*WIDTH-1:0];
    quo     = (sign_a ^ sign_b) ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem     = sign_a ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    fixed   = op_div ? {rem, quo} : product;
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    HiLoEn     = 1'b0;
    DivByZero  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          next_state = start_zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (count == LAST) begin
          next_state = FIX;
        end
      end
      FIX: begin
        Busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        HiLoEn     = 1'b1;
        DivByZero  = zero_div;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, iterate in RUN, publish the corrected result on entry to DONE
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      zero_div  <= 1'b0;
      count     <= '0;
      operand   <= '0;
      acc       <= '0;
      HiLoWrite <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_div   <= Op[1];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            zero_div <= start_zero_div;
            count    <= '0;
            if (Op[1]) begin
              operand <= b_mag;
              acc     <= {{(WIDTH+1){1'b0}}, a_mag};
            end else begin
              operand <= a_mag;
              acc     <= {{(WIDTH+1){1'b0}}, b_mag};
            end
            if (start_zero_div) begin
              HiLoWrite <= {A, {WIDTH{1'b1}}};
            end
          end
        end
        RUN: begin
          acc   <= op_div ? div_next : mul_next;
          count <= count + CW'(1);
        end
        FIX: begin
          HiLoWrite <= fixed;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, randomized
// operations against a plain-arithmetic reference, and control scenarios.
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic        DivByZero;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  // Reference result computed with ordinary 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 0) ? 1 : LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h00000001;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at the negedge of cycle 1 after a Start edge; watches until Done, then steps one more cycle
  task automatic wait_done(input int limit, output int cyc, output int busy_cyc,
                           output logic [63:0] res, output logic zf, output logic en,
                           output logic busy_after);
    bit found = 0;
    cyc = 0; busy_cyc = 0; res = '0; zf = 1'b0; en = 1'b0; busy_after = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      if (Busy) busy_cyc++;
      if (Done) begin
        cyc = k; res = HiLoWrite; zf = DivByZero; en = HiLoEn;
        found = 1;
        @(negedge Clk);
        busy_after = Busy;
        break;
      end
      @(negedge Clk);
    end
    if (!found) $display("[TB] no Done within %0d cycles", limit);
  endtask

  // Pulse Start for one cycle with the given operation, then scramble the inputs
  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int busy_cyc, output logic [63:0] res,
                          output logic zf, output logic en, output logic busy_after);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
    wait_done(60, cyc, busy_cyc, res, zf, en, busy_after);
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    #3;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || HiLoEn !== 1'b0 || DivByZero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: got busy=%b done=%b en=%b dbz=%b expected all 0", Busy, Done, HiLoEn, DivByZero);
    end
    checks++;
    if (HiLoWrite !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_hilo: got %h expected 0", HiLoWrite);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", Busy);
    end
  endtask

  // Directed multiply, divide, overflow and divide-by-zero vectors
  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd100,
                             32'hFFFFFFF9, 32'h80000000, 32'h12345678, 32'hDEADBEEF};
    logic [31:0] bs  [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd7,
                             32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [63:0] want[8] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                             64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000,
                             64'h12345678_FFFFFFFF, 64'hDEADBEEF_FFFFFFFF};
    int          lat [8] = '{LAT, LAT, LAT, LAT, LAT, LAT, 1, 1};
    int cyc, busy_cyc;
    logic [63:0] res;
    logic zf, en, busy_after;
    for (int i = 0; i < 8; i++) begin
      issue_op(ops[i], as[i], bs[i], cyc, busy_cyc, res, zf, en, busy_after);
      checks++;
      if (cyc != lat[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, cyc, lat[i]);
      end
      checks++;
      if (busy_cyc != lat[i] || busy_after !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed%0d_busy: got %0d cycles (after=%b) expected %0d", i, busy_cyc, busy_after, lat[i]);
      end
      checks++;
      if (res !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_result: got %h expected %h", i, res, want[i]);
      end
      checks++;
      if (en !== 1'b1 || zf !== (lat[i] == 1)) begin
        errors++;
        $display("[TB] FAIL directed%0d_flags: got en=%b dbz=%b expected en=1 dbz=%b", i, en, zf, lat[i] == 1);
      end
    end
  endtask

  task automatic test_random();
    int cyc, busy_cyc, exp_lat;
    logic [63:0] res, exp_res;
    logic zf, en, busy_after;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      exp_res = ref_result(op, a, b);
      exp_lat = ref_latency(op, b);
      issue_op(op, a, b, cyc, busy_cyc, res, zf, en, busy_after);
      checks++;
      if (res !== exp_res || cyc != exp_lat) begin
        errors++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got %h at cycle %0d expected %h at cycle %0d",
                 i, op, a, b, res, cyc, exp_res, exp_lat);
      end
      checks++;
      if (en !== 1'b1 || zf !== (exp_lat == 1) || busy_after !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random%0d_flags: got en=%b dbz=%b busy_after=%b expected en=1 dbz=%b busy_after=0",
                 i, en, zf, busy_after, exp_lat == 1);
      end
    end
  endtask

  // A Start pulse during a running operation must be dropped entirely
  task automatic test_ignored_start();
    int cyc, busy_cyc;
    int late_busy = 0;
    logic [63:0] res;
    logic zf, en, busy_after;
    Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(60, cyc, busy_cyc, res, zf, en, busy_after);
    checks++;
    if (res !== 64'h00000000_0000001E || cyc != LAT - 10) begin
      errors++;
      $display("[TB] FAIL ignored_start_result: got %h at cycle %0d expected 1e at cycle %0d", res, cyc + 10, LAT);
    end
    for (int k = 0; k < 5; k++) begin
      if (Busy) late_busy++;
      @(negedge Clk);
    end
    checks++;
    if (late_busy != 0 || busy_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_start_queued: got %0d busy cycles after Done expected 0", late_busy);
    end
  endtask

  // Start held high across Done is accepted again on the single IDLE cycle
  task automatic test_back_to_back();
    int cyc, busy_cyc, exp_lat2;
    logic [63:0] res, exp1, exp2;
    logic zf, en, busy_after;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'h1;
    exp1 = ref_result(2'b01, a1, b1);
    exp2 = ref_result(2'b10, a2, b2);
    exp_lat2 = ref_latency(2'b10, b2);
    Start = 1'b1; Op = 2'b01; A = a1; B = b1;
    @(negedge Clk);
    Op = 2'b10; A = a2; B = b2;
    wait_done(60, cyc, busy_cyc, res, zf, en, busy_after);
    checks++;
    if (res !== exp1 || cyc != LAT || busy_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h at cycle %0d busy_after=%b expected %h at cycle %0d busy_after=0",
               res, cyc, busy_after, exp1, LAT);
    end
    @(negedge Clk);
    Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
    wait_done(60, cyc, busy_cyc, res, zf, en, busy_after);
    checks++;
    if (res !== exp2 || cyc != exp_lat2) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h at cycle %0d expected %h at cycle %0d", res, cyc, exp2, exp_lat2);
    end
  endtask

  // Asynchronous reset in mid-division aborts it without a HiLo write
  task automatic test_reset_abort();
    int cyc, busy_cyc;
    int stray = 0;
    logic [63:0] res;
    logic zf, en, busy_after;
    Start = 1'b1; Op = 2'b10; A = 32'hFFFFFF00; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || HiLoEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_status: got busy=%b done=%b en=%b expected 0", Busy, Done, HiLoEn);
    end
    checks++;
    if (HiLoWrite !== 64'h0) begin
      errors++;
      $display("[TB] FAIL abort_hilo: got %h expected 0", HiLoWrite);
    end
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (HiLoEn || Busy) stray++;
      @(negedge Clk);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL abort_stray_write: got %0d active cycles expected 0", stray);
    end
    issue_op(2'b10, 32'hFFFFFFF9, 32'd2, cyc, busy_cyc, res, zf, en, busy_after);
    checks++;
    if (res !== ref_result(2'b10, 32'hFFFFFFF9, 32'd2) || cyc != LAT) begin
      errors++;
      $display("[TB] FAIL abort_recovery: got %h at cycle %0d expected %h at cycle %0d",
               res, cyc, ref_result(2'b10, 32'hFFFFFFF9, 32'd2), LAT);
    end
  endtask

  // Done, HiLoEn and DivByZero must always move together as a single pulse
  always @(negedge Clk) begin
    if (!Rst && (HiLoEn !== Done || (DivByZero === 1'b1 && Done !== 1'b1))) begin
      checks++;
      errors++;
      $display("[TB] FAIL strobe_alignment: got done=%b en=%b dbz=%b expected en==done and dbz only with done",
               Done, HiLoEn, DivByZero);
    end
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative 32-bit multiply/divide engine for MULT, MULTU, DIV and DIVU. It sits directly upstream of the HiLo register. It accepts operands from the register-file read ports (rs, rt) on a Start pulse from the controller. It produces the 64-bit {Hi,Lo} result together with a one-cycle write-enable that drives the HiLo register's WriteEnable/WriteData inputs.

Parameters:
WIDTH, 32, operand width; also the number of iteration cycles (Hi/Lo each WIDTH bits).

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  request pulse; sampled only in IDLE.
Op  input  2  operation select, latched with Start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
A  input  WIDTH  operand rs (multiplicand / dividend).
B  input  WIDTH  operand rt (multiplier / divisor).
Busy  output  1  high whenever the state is not IDLE.
Done  output  1  one-cycle pulse; result valid.
HiLoEn  output  1  one-cycle HiLo write enable, coincident with Done.
HiLoWrite  output  2*WIDTH  {Hi,Lo} result; registered, held until the next Done.
DivByZero  output  1  pulses with Done when a DIV/DIVU had B==0.

Behaviour:
- Reset (asynchronous, any state):
  - state is IDLE.
  - Busy, Done, HiLoEn, DivByZero, HiLoWrite and all internal registers are 0.
  - An operation in progress is aborted; no HiLoEn is issued for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If Start=1, latch Op, the sign flags and the operand magnitudes.
    - Signed ops: magnitude is the two's-complement absolute value. 0x80000000 stays 0x80000000, treated as unsigned.
    - Unsigned ops: raw values.
  - Clear the iteration counter.
  - Go to RUN. Exception: divide with B==0 goes straight to DONE.
  - Start=0: stay in IDLE.
- RUN: exactly WIDTH cycles, one bit per cycle; counter 0..WIDTH-1. After the last iteration, go to FIX.
  - Multiply: shift-add. If multiplier LSB is set, add multiplicand to the upper half of the 2*WIDTH+1 accumulator. Then shift the accumulator right by 1.
  - Divide: restoring. Shift {remainder,quotient} left by 1. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
- FIX: one cycle of sign correction.
  - MULT: negate the 64-bit product if the signs of A and B differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if A is negative.
  - Unsigned ops: pass the result through.
  - Then go to DONE.
- DONE: one cycle.
  - Done=1 and HiLoEn=1.
  - HiLoWrite is updated at entry to DONE.
    - Multiply: {product[63:32], product[31:0]}.
    - Divide: {remainder, quotient}.
  - Return to IDLE.
- Latency:
  - Start sampled at edge n gives Done high in cycle n+WIDTH+2 (34 cycles for WIDTH=32).
  - Busy is high for WIDTH+2 cycles.
- Divide by zero (DIV or DIVU with B==0):
  - IDLE goes to DONE directly; Done is high the cycle after the Start edge.
  - HiLoWrite = {A, all-ones}; DivByZero=1 for that cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. No flag.
- Start while Busy=1 is ignored; it is neither queued nor does it alter operands.
- Start held high through DONE is accepted again on the first IDLE cycle (back-to-back operation).
- Operands A, B and Op may change freely after the Start edge; the engine uses only the latched copies.
- Done, HiLoEn and DivByZero are never high outside DONE.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, Start 1 cycle -> Busy 34 cycles; Done/HiLoEn pulse in cycle 34 with HiLoWrite=0xFFFFFFFE_00000001.
2. MULT A=0xFFFFFFFD (-3), B=7 -> HiLoWrite=0xFFFFFFFF_FFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> 0x40000000_00000000.
3. DIVU A=100, B=7 -> Lo=14, Hi=2. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
4. DIVU A=0x12345678, B=0 -> Done, HiLoEn and DivByZero high the cycle after the Start edge; HiLoWrite=0x12345678_FFFFFFFF; Busy high 1 cycle.
5. Start a MULTU (5x6), pulse Start with DIVU operands at cycle 10 -> second Start ignored; result 0x00000000_0000001E at cycle 34.
6. Assert Rst asynchronously at cycle 15 of a DIV -> Busy, Done and HiLoEn drop immediately; HiLoWrite=0; no HiLoEn afterwards. Next Start after release runs normally.
